// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - shared opcodes and FSM state type for the ALU share arbiter
//
// Contents:
//   OP_* : 3-bit ALU opcodes. OP_RSVD (3'b110) is the reserved encoding.
//   state_t : arbiter FSM states IDLE / EXEC / RESP.
//   is_rsvd_op() : true for the reserved opcode.
package alu_share_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;  // A & ~B
  localparam logic [2:0] OP_ORN  = 3'b101;  // A | ~B
  localparam logic [2:0] OP_RSVD = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_rsvd_op(input logic [2:0] sel);
    return (sel == OP_RSVD);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant picker
//
// Picks the first set bit of req at or after ptr, wrapping modulo NREQ.
// The pointer register lives in the parent; this block holds no state.
//
// Ports:
//   req    : in  NREQ  request vector
//   ptr    : in  IDW   highest-priority index for this cycle
//   gnt    : out NREQ  one-hot grant, zero when no request is set
//   gnt_id : out IDW   encoded grant index (0 when no request is set)
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  int   idx;
  logic found;

  // Scan NREQ slots starting at ptr; the modulo keeps non-power-of-two
  // NREQ values wrapping correctly.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between NREQ requesters
//
// Optional feature macro: ALU_SHARE_OPCHK_EN (reserved-opcode check, adds rsp_err).
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/req_ready: per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b        : packed operands, requester i at [i*N +: N]
//   req_sel            : packed opcodes, requester i at [i*3 +: 3]
//   alu_a/alu_b/alu_sel: registered drive to the shared ALU
//   alu_y/alu_cout/alu_zero : ALU results
//   rsp_valid/rsp_ready: response handshake
//   rsp_id             : requester served
//   rsp_y/rsp_cout/rsp_zero : captured ALU results
//   rsp_err            : reserved opcode flag (only with ALU_SHARE_OPCHK_EN)
//   busy               : high whenever the FSM is not IDLE
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter  int N    = 32,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*3-1:0] req_sel,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic [2:0]        alu_sel,
  input  logic [N-1:0]      alu_y,
  input  logic              alu_cout,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_y,
  output logic              rsp_cout,
  output logic              rsp_zero,
`ifdef ALU_SHARE_OPCHK_EN
  output logic              rsp_err,
`endif
  output logic              busy
);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  cur_id;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            grant_any;
  logic [N-1:0]    g_a;
  logic [N-1:0]    g_b;
  logic [2:0]      g_sel;
  logic [IDW-1:0]  ptr_next;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // The grant is only offered in IDLE, so the handshake completes in the
  // same cycle the arbiter chooses.
  assign grant_any = (state == IDLE) && (|gnt);
  assign req_ready = (state == IDLE) ? gnt : '0;
  assign busy      = (state != IDLE);
  assign rsp_id    = cur_id;

  assign g_a   = req_a[int'(gnt_id)*N +: N];
  assign g_b   = req_b[int'(gnt_id)*N +: N];
  assign g_sel = req_sel[int'(gnt_id)*3 +: 3];

  // Pointer moves past the requester just served, wrapping at NREQ.
  assign ptr_next = (cur_id == IDW'(NREQ-1)) ? '0 : cur_id + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_id    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= 3'b000;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_cout  <= 1'b0;
      rsp_zero  <= 1'b0;
`ifdef ALU_SHARE_OPCHK_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            cur_id <= gnt_id;
`ifdef ALU_SHARE_OPCHK_EN
            // Reserved opcode: answer directly, leave the ALU inputs alone.
            if (is_rsvd_op(g_sel)) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_y     <= '0;
              rsp_cout  <= 1'b0;
              rsp_zero  <= 1'b0;
              state     <= RESP;
            end else begin
              alu_a   <= g_a;
              alu_b   <= g_b;
              alu_sel <= g_sel;
              state   <= EXEC;
            end
`else
            alu_a   <= g_a;
            alu_b   <= g_b;
            alu_sel <= g_sel;
            state   <= EXEC;
`endif
          end
        end
        EXEC: begin
          // One cycle for the combinational ALU to settle on the registers.
          rsp_y     <= alu_y;
          rsp_cout  <= alu_cout;
          rsp_zero  <= alu_zero;
          rsp_valid <= 1'b1;
`ifdef ALU_SHARE_OPCHK_EN
          rsp_err   <= 1'b0;
`endif
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= ptr_next;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ*3-1:0] req_sel;
  logic [N-1:0]      alu_a;
  logic [N-1:0]      alu_b;
  logic [2:0]        alu_sel;
  logic [N-1:0]      alu_y;
  logic              alu_cout;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_y;
  logic              rsp_cout;
  logic              rsp_zero;
  logic              busy;
`ifdef ALU_SHARE_OPCHK_EN
  logic              rsp_err;
`endif

  int n_pass  = 0;
  int n_total = 0;

  alu_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_y     (alu_y),
    .alu_cout  (alu_cout),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_cout  (rsp_cout),
    .rsp_zero  (rsp_zero),
`ifdef ALU_SHARE_OPCHK_EN
    .rsp_err   (rsp_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: {cout, y}. Unknown opcode falls back to AND.
  function automatic logic [N:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic [2:0] s);
    case (s)
      3'b000: return {1'b0, a & b};
      3'b001: return {1'b0, a | b};
      3'b010: return {1'b0, a} + {1'b0, b};
      3'b011: return {1'b0, a} - {1'b0, b};
      3'b100: return {1'b0, a & ~b};
      3'b101: return {1'b0, a | ~b};
      3'b111: return {1'b0, {(N-1){1'b0}}, ($signed(a) < $signed(b))};
      default: return {1'b0, a & b};
    endcase
  endfunction

  assign {alu_cout, alu_y} = alu_f(alu_a, alu_b, alu_sel);
  assign alu_zero = (alu_y == '0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int id, input logic [2:0] s, input logic [N-1:0] a,
                         input logic [N-1:0] b);
    req_valid[id]      = 1'b1;
    req_a[id*N +: N]   = a;
    req_b[id*N +: N]   = b;
    req_sel[id*3 +: 3] = s;
  endtask

  // Issues one op at the current negedge; returns at the negedge of T+2.
  task automatic issue_op(input int id, input logic [2:0] s, input logic [N-1:0] a,
                          input logic [N-1:0] b, input string tag);
    set_req(id, s, a, b);
    #1;
    chk({tag, "_ready"}, req_ready, 64'(1 << id));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk({tag, "_exec_novalid"}, rsp_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, "_valid_T2"}, rsp_valid, 1);
    chk({tag, "_id"}, rsp_id, id);
  endtask

  typedef struct {
    int         id;
    logic [2:0] sel;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] y;
    logic       cout;
    logic       zero;
  } vec_t;

`ifdef ALU_SHARE_OPCHK_EN
  localparam int NTBL = 10;
`else
  localparam int NTBL = 11;
`endif
  vec_t tbl[11];

  // Reference model state for the random phase.
  int           m_ph;
  int           m_ptr;
  int           m_id;
  logic [N-1:0] m_y;
  logic         m_cout;
  logic         m_zero;
  logic         m_err;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ids[$];
    int cyc[$];
    int c;
    logic [N-1:0] hold_y;

    tbl[0]  = '{1, OP_ADD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0};
    tbl[1]  = '{0, OP_SUB,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1};
    tbl[2]  = '{2, OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
    tbl[3]  = '{3, OP_OR,   32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1'b0};
    tbl[4]  = '{1, OP_ANDN, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0};
    tbl[5]  = '{2, OP_ORN,  32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0};
    tbl[6]  = '{3, OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    tbl[7]  = '{0, OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1};
    tbl[8]  = '{1, OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1};
    tbl[9]  = '{2, OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[10] = '{3, OP_RSVD, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};

    // Reset / idle
    apply_reset();
    @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id",    rsp_id, 0);
    chk("rst_rsp_y",     rsp_y, 0);
    chk("rst_rsp_cout",  rsp_cout, 0);
    chk("rst_rsp_zero",  rsp_zero, 0);
    chk("rst_alu_a",     alu_a, 0);
    chk("rst_alu_b",     alu_b, 0);
    chk("rst_alu_sel",   alu_sel, 0);
    chk("rst_busy",      busy, 0);
`ifdef ALU_SHARE_OPCHK_EN
    chk("rst_rsp_err",   rsp_err, 0);
`endif

    // Table-driven single ops
    for (int i = 0; i < NTBL; i++) begin
      @(negedge clk);
      issue_op(tbl[i].id, tbl[i].sel, tbl[i].a, tbl[i].b, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_y", i),    rsp_y,    tbl[i].y);
      chk($sformatf("tbl%0d_cout", i), rsp_cout, tbl[i].cout);
      chk($sformatf("tbl%0d_zero", i), rsp_zero, tbl[i].zero);
`ifdef ALU_SHARE_OPCHK_EN
      chk($sformatf("tbl%0d_err", i),  rsp_err,  0);
`endif
      @(negedge clk);
      #1;
      chk($sformatf("tbl%0d_done", i), rsp_valid, 0);
      chk($sformatf("tbl%0d_idle", i), busy, 0);
    end

    // Round-robin with all four requesters held valid
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, OP_ADD, 32'(i), 32'h10);
    for (int t = 0; t < 20; t++) begin
      #1;
      if (req_ready != 0) begin
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) ids.push_back(k);
        cyc.push_back(t);
      end
      @(negedge clk);
    end
    clear_inputs();
    chk("rr_count_ge5", (ids.size() >= 5), 1);
    if (ids.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk($sformatf("rr_id%0d", k), ids[k], k % NREQ);
      for (int k = 1; k < 5; k++) chk($sformatf("rr_gap%0d", k), cyc[k] - cyc[k-1], 3);
    end

    // Pointer at 2 with requesters 0,1,3 valid -> 3 wins
    apply_reset();
    @(negedge clk);
    issue_op(1, OP_OR, 32'h1, 32'h2, "p2");
    @(negedge clk);
    set_req(0, OP_AND, 32'h0, 32'h0);
    set_req(1, OP_AND, 32'h0, 32'h0);
    set_req(3, OP_ADD, 32'h7, 32'h1);
    #1;
    chk("p2_grant3", req_ready, 4'b1000);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    #1;
    chk("p2_rsp_id", rsp_id, 3);
    chk("p2_rsp_y",  rsp_y, 32'h8);

    // Backpressure: response held for 5 cycles with other requests pending
    apply_reset();
    @(negedge clk);
    rsp_ready = 1'b0;
    issue_op(2, OP_ADD, 32'h0000_0100, 32'h0000_0023, "bp");
    hold_y = rsp_y;
    chk("bp_y", hold_y, 32'h0000_0123);
    for (int i = 0; i < NREQ; i++) set_req(i, OP_AND, 32'hFFFF, 32'hFF);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp_valid%0d", t), rsp_valid, 1);
      chk($sformatf("bp_hold_y%0d", t), rsp_y, hold_y);
      chk($sformatf("bp_hold_id%0d", t), rsp_id, 2);
      chk($sformatf("bp_noready%0d", t), req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_released", rsp_valid, 0);
    chk("bp_next_grant3", req_ready, 4'b1000);
    clear_inputs();

    // Reset during EXEC: op discarded, pointer back to 0
    apply_reset();
    @(negedge clk);
    issue_op(1, OP_ADD, 32'h1, 32'h1, "pre");
    @(negedge clk);
    set_req(2, OP_SUB, 32'h9, 32'h4);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("mr_in_exec", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy0",  busy, 0);
    chk("mr_valid0", rsp_valid, 0);
    chk("mr_alu_a0", alu_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mr_norsp%0d", t), rsp_valid, 0);
    end
    for (int i = 0; i < NREQ; i++) set_req(i, OP_OR, 32'h5, 32'h0);
    #1;
    chk("mr_ptr0", req_ready, 4'b0001);
    @(negedge clk);
    clear_inputs();
`ifdef ALU_SHARE_OPCHK_EN
    // Reserved opcode answered at T+1 with rsp_err
    apply_reset();
    @(negedge clk);
    set_req(2, OP_RSVD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1;
    chk("rsvd_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rsvd_valid_T1", rsp_valid, 1);
    chk("rsvd_err",  rsp_err, 1);
    chk("rsvd_y",    rsp_y, 0);
    chk("rsvd_cout", rsp_cout, 0);
    chk("rsvd_zero", rsp_zero, 0);
    chk("rsvd_id",   rsp_id, 2);
    chk("rsvd_alu_idle", alu_sel, 0);
    @(negedge clk);
    issue_op(3, OP_ADD, 32'h2, 32'h2, "post_rsvd");
    chk("post_rsvd_err", rsp_err, 0);
    chk("post_rsvd_y",   rsp_y, 32'h4);
    @(negedge clk);
`endif

    // Randomized traffic against a transaction-level model
    apply_reset();
    m_ph = 0; m_ptr = 0; m_id = 0;
    m_y = '0; m_cout = 1'b0; m_zero = 1'b0; m_err = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      req_valid = 4'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*N +: N]   = ($urandom_range(0, 3) == 0) ? req_b[i*N +: N] : $urandom;
        req_b[i*N +: N]   = $urandom;
        req_sel[i*3 +: 3] = 3'($urandom);
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      #1;
      c = -1;
      if (m_ph == 0)
        for (int k = 0; k < NREQ; k++)
          if (c < 0 && req_valid[(m_ptr + k) % NREQ]) c = (m_ptr + k) % NREQ;
      chk($sformatf("rnd%0d_ready", t), req_ready, (c >= 0) ? 64'(1 << c) : 64'd0);
      chk($sformatf("rnd%0d_busy", t), busy, m_ph != 0);
      chk($sformatf("rnd%0d_valid", t), rsp_valid, m_ph == 2);
      if (m_ph == 2) begin
        chk($sformatf("rnd%0d_id", t),   rsp_id, m_id);
        chk($sformatf("rnd%0d_y", t),    rsp_y, m_y);
        chk($sformatf("rnd%0d_cout", t), rsp_cout, m_cout);
        chk($sformatf("rnd%0d_zero", t), rsp_zero, m_zero);
`ifdef ALU_SHARE_OPCHK_EN
        chk($sformatf("rnd%0d_err", t),  rsp_err, m_err);
`endif
      end
      case (m_ph)
        0: if (c >= 0) begin
          m_id = c;
          {m_cout, m_y} = alu_f(req_a[c*N +: N], req_b[c*N +: N], req_sel[c*3 +: 3]);
          m_zero = (m_y == '0);
          m_err  = 1'b0;
          m_ph   = 1;
`ifdef ALU_SHARE_OPCHK_EN
          if (req_sel[c*3 +: 3] == 3'b110) begin
            m_y = '0; m_cout = 1'b0; m_zero = 1'b0; m_err = 1'b1;
            m_ph = 2;
          end
`endif
        end
        1: m_ph = 2;
        default: if (rsp_ready) begin
          m_ptr = (m_id + 1) % NREQ;
          m_ph  = 0;
        end
      endcase
    end
    clear_inputs();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU with zero flag between NREQ requesters.
- Each requester presents an operation (a, b, sel) with a valid/ready handshake.
- A round-robin arbiter grants one requester at a time. The block drives the ALU inputs from registers, captures the ALU outputs, and returns a tagged response.
- Sits between instruction-issue clients and the shared ALU instance.

Parameters:
- N, 32, operand/result width; must match the ALU's N.
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), requester ID width (derived; not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester operation valid
- req_ready  output  NREQ  per-requester accept; one-hot or zero
- req_a  input  NREQ*N  packed operand A; requester i at [i*N +: N]
- req_b  input  NREQ*N  packed operand B
- req_sel  input  NREQ*3  packed opcode; requester i at [i*3 +: 3]
- alu_a  output  N  to ALU a
- alu_b  output  N  to ALU b
- alu_sel  output  3  to ALU sel
- alu_y  input  N  from ALU y
- alu_cout  input  1  from ALU cout
- alu_zero  input  1  from ALU Z_flag
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accept
- rsp_id  output  IDW  ID of the requester served
- rsp_y  output  N  captured result
- rsp_cout  output  1  captured carry/overflow
- rsp_zero  output  1  captured zero flag
- busy  output  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, rr pointer=0, and all outputs 0 (req_ready, rsp_*, alu_a, alu_b, alu_sel=3'b000, busy).
- Opcodes: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 A&~B, 101 A|~B, 111 SLT. 110 is reserved.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, the arbiter picks the first set bit at or after the rr pointer, wrapping modulo NREQ.
  - req_ready[g] is asserted combinationally in that same cycle, so the handshake completes in that cycle.
  - Register alu_a/alu_b/alu_sel from requester g and register the grant ID. Go to EXEC.
  - If no req_valid is set, stay in IDLE with req_ready=0.
- EXEC (exactly 1 cycle): the ALU settles on the registered inputs. At the clock edge, capture alu_y, alu_cout and alu_zero into rsp_y/rsp_cout/rsp_zero, set rsp_valid=1, and go to RESP.
- RESP:
  - Hold all rsp_* stable while rsp_valid && !rsp_ready.
  - When rsp_ready=1, clear rsp_valid, set rr pointer = grant+1 (mod NREQ), and go to IDLE.
  - No new grant is issued in the same cycle; at most one operation is in flight.
- Latency: the request handshake is at cycle T, rsp_valid rises at T+2, and the earliest next grant is at T+3.
- Throughput: 1 op per 3 cycles with rsp_ready held high.
- Arbitration rules:
  - The pointer advances only on response completion.
  - A requester that is granted and then drops req_valid later has no effect; its operation is already latched.
  - req_valid dropped before the grant is simply not seen.
- Inputs: alu_a/alu_b/alu_sel stay at their last values outside EXEC. rsp_zero is taken from the ALU as-is, not recomputed.
- Reset mid-operation: rst_n low in any state forces IDLE immediately. The in-flight op is discarded, no response is issued, and the rr pointer returns to 0.
- Simultaneous events: all NREQ requests valid continuously -> grants 0,1,2,3,0,...; with 3 valid at pointer 2 -> next grant is 3.

Optional Feature:
- Macro: ALU_SHARE_OPCHK_EN.
- Defined:
  - Adds output rsp_err (1 bit, reset 0).
  - A granted op with sel=3'b110 skips EXEC and goes directly IDLE->RESP: rsp_valid at T+1, rsp_err=1, rsp_y=0, rsp_cout=0, rsp_zero=0. The ALU is not driven.
  - rsp_err=0 for all legal ops.
- Undefined:
  - No rsp_err port.
  - sel=110 passes to the ALU like any other op; the result is whatever the ALU's default produces (AND).

Decomposition:
- Package alu_share_pkg:
  - Opcode localparams OP_AND..OP_SLT and OP_RSVD=3'b110.
  - State enum typedef {IDLE, EXEC, RESP}.
- Sub-module rr_arbiter (parameter NREQ):
  - Inputs: req vector, pointer. Outputs: one-hot grant and encoded ID, purely combinational.
  - Pointer storage stays in the parent.

Test Plan:
- Reset/idle: rst_n low then high with no requests -> all outputs 0 and busy=0.
- Single op: req 1 ADD a=32'h0000_0005 b=32'h0000_0003 at T -> rsp_valid at T+2 with rsp_id=1, rsp_y=8, rsp_zero=0.
- Zero flag: req 0 SUB a=b=32'h1234_5678 -> rsp_y=0, rsp_zero=1.
- Round-robin: all 4 valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 with each response 3 cycles apart.
- Backpressure and mid-op reset:
  - rsp_ready=0 for 5 cycles -> rsp_* held stable, no req_ready asserted, then completes.
  - rst_n pulsed during EXEC -> no response, pointer=0.
- With ALU_SHARE_OPCHK_EN defined: req 2 sel=110 -> rsp_valid at T+1 with rsp_err=1, rsp_y=0; the next legal op gives rsp_err=0.
